tracer_frame_sched: RTL and testbench
=====================================

// Module: tracer_frame_sched
// PURPOSE
//   Per-frame scheduler for the 8-segment contour tracer chain and its load/store controller.
//   Each frame it runs cfg_num_batch batches of 8 ROIs back-to-back. For every batch it:
//     - issues one load_start pulse;
//     - waits for store_end;
//     - advances the batch index and the tracer-buffer base address.
//   Also reports frame completion, counts frame overruns and aborts a stalled batch via a watchdog.
// PARAMETERS
//   BATCH_W       6          width of batch count/index (max 63 batches/frame)
//   TO_W          24         watchdog counter width
//   TIMEOUT_CYC   24'hFFFFFF cycles in WAIT before abort
//   BATCH_STRIDE  32'd64     tracer-buffer byte stride per batch
// PORTS
//   s_axi_aclk     in   1        single clock
//   s_axi_reset    in   1        synchronous, active-high reset
//   cfg_enable     in   1        scheduler enable, sampled in IDLE only
//   cfg_num_batch  in   BATCH_W  batches per frame, latched at frame accept
//   frame_start    in   1        1-cycle pulse, new downsampled frame available
//   load_start     out  1        1-cycle pulse to the tracer load controller
//   store_end      in   1        1-cycle pulse, batch traces stored
//   batch_idx      out  BATCH_W  current batch index
//   buf_base       out  32       batch_idx*BATCH_STRIDE, tracer-buffer base address
//   busy           out  1        high in any state except IDLE
//   frame_done     out  1        1-cycle pulse, all batches of the frame stored
//   abort          out  1        1-cycle pulse, watchdog expired
//   timeout_err    out  1        sticky watchdog flag
//   overrun_cnt    out  16       saturating count of frame_start pulses received while busy
//   err_clr        in   1        1-cycle pulse, clears timeout_err and overrun_cnt
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, watchdog 0, latched count 0. Reset mid-frame abandons the frame with no pulses.
//   - All outputs are registered.
//   - States:
//     - IDLE: frame_start & cfg_enable & cfg_num_batch!=0 -> LAUNCH. Latch nb=cfg_num_batch; batch_idx=0; buf_base=0.
//       frame_start with cfg_enable=0 or cfg_num_batch=0 is ignored and not counted.
//     - LAUNCH: load_start=1 for exactly this cycle; watchdog cleared -> WAIT.
//     - WAIT: watchdog increments each cycle.
//       - store_end -> NEXT.
//       - else watchdog==TIMEOUT_CYC-1 -> IDLE, abort=1, timeout_err=1.
//       - store_end in the expiry cycle wins (no abort).
//     - NEXT: batch_idx==nb-1 -> DONE. Else batch_idx+1, buf_base+BATCH_STRIDE -> LAUNCH.
//     - DONE: frame_done=1 for this cycle -> IDLE.
//   - Latency:
//     - frame_start accepted at cycle T -> load_start high at T+1.
//     - store_end at S -> next load_start at S+2, or frame_done at S+2 on the last batch.
//   - store_end outside WAIT is ignored.
//   - frame_start while busy: frame dropped, overrun_cnt+1 (saturates at 16'hFFFF). Current frame continues.
//   - cfg_enable deasserted mid-frame: current frame completes; the next frame is not accepted.
//   - cfg_num_batch changes mid-frame have no effect (latched copy used).
//   - err_clr applied before same-cycle events:
//     - err_clr with a timeout -> timeout_err=1;
//     - err_clr with an overrun -> overrun_cnt=1.
//   - buf_base arithmetic is 32-bit, computed incrementally; no wrap within 63*BATCH_STRIDE.
// TESTING
//   1. num_batch=3, frame_start, store_end 10 cycles after each load_start
//      -> 3 load_start pulses, batch_idx 0,1,2, buf_base 0,64,128, one frame_done, busy drops after it.
//   2. frame_start during batch 1 of a 3-batch frame -> overrun_cnt=1, frame still completes with 3 batches.
//      err_clr -> overrun_cnt=0.
//   3. TIMEOUT_CYC=16, no store_end -> abort and timeout_err at 16th WAIT cycle, state IDLE, no frame_done.
//      Repeat with store_end on the 16th cycle -> no abort.
//   4. cfg_enable=0 or cfg_num_batch=0 with frame_start -> no load_start, busy stays 0, overrun_cnt unchanged.
//   5. s_axi_reset asserted in WAIT of batch 2 -> next cycle all outputs 0.
//      Next frame_start restarts from batch_idx=0.
//   6. 70000 frame_start pulses while busy -> overrun_cnt saturates at 16'hFFFF.
//      Stray store_end while IDLE -> no state change.

Source files
------------

// File: rtl/tracer_frame_sched.sv
// Per-frame batch scheduler for the 8-segment contour tracer chain.
// For each accepted frame it issues cfg_num_batch load/store rounds, one at a
// time. Every round moves the tracer-buffer base address forward by one stride.
// It also reports frame completion, counts dropped frames and aborts a stalled
// batch with a watchdog.
module tracer_frame_sched #(
    parameter int                 BATCH_W      = 6,
    parameter int                 TO_W         = 24,
    parameter logic [TO_W-1:0]    TIMEOUT_CYC  = 24'hFFFFFF,
    parameter logic [31:0]        BATCH_STRIDE = 32'd64
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_reset,
    input  logic               cfg_enable,
    input  logic [BATCH_W-1:0] cfg_num_batch,
    input  logic               frame_start,
    output logic               load_start,
    input  logic               store_end,
    output logic [BATCH_W-1:0] batch_idx,
    output logic [31:0]        buf_base,
    output logic               busy,
    output logic               frame_done,
    output logic               abort,
    output logic               timeout_err,
    output logic [15:0]        overrun_cnt,
    input  logic               err_clr
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Last watchdog value before the stalled batch is abandoned.
    localparam logic [TO_W-1:0] WD_LAST = TIMEOUT_CYC - TO_W'(1);

    state_t             state_r;
    state_t             state_s;
    logic [BATCH_W-1:0] nb_r;
    logic [BATCH_W-1:0] nb_s;
    logic [BATCH_W-1:0] batch_idx_r;
    logic [BATCH_W-1:0] idx_s;
    logic [31:0]        buf_base_r;
    logic [31:0]        base_s;
    logic [TO_W-1:0]    wd_r;
    logic [TO_W-1:0]    wd_s;
    logic               abort_s;
    logic               load_start_r;
    logic               frame_done_r;
    logic               abort_r;
    logic               busy_r;
    logic               timeout_err_r;
    logic               timeout_err_s;
    logic [15:0]        overrun_cnt_r;
    logic [15:0]        ovr_base_s;
    logic [15:0]        overrun_cnt_s;

    // Next-state logic: sequencing of one frame, batch index/base and watchdog.
    always_comb begin
        state_s = state_r;
        nb_s    = nb_r;
        idx_s   = batch_idx_r;
        base_s  = buf_base_r;
        wd_s    = wd_r;
        abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start && cfg_enable && (cfg_num_batch != {BATCH_W{1'b0}})) begin
                    state_s = ST_LAUNCH;
                    nb_s    = cfg_num_batch;
                    idx_s   = {BATCH_W{1'b0}};
                    base_s  = 32'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                wd_s    = {TO_W{1'b0}};
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A store_end that arrives in the expiry cycle still completes the batch.
                if (store_end) begin
                    state_s = ST_NEXT;
                end else if (wd_r == WD_LAST) begin
                    state_s = ST_IDLE;
                    abort_s = 1'b1;
                end else begin
                    wd_s = wd_r + TO_W'(1);
                end
            end
            ST_NEXT: begin
                if (batch_idx_r == (nb_r - BATCH_W'(1))) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s   = batch_idx_r + BATCH_W'(1);
                    base_s  = buf_base_r + BATCH_STRIDE;
                    state_s = ST_LAUNCH;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Error bookkeeping: err_clr takes effect first, then same-cycle events are added.
    always_comb begin
        if (err_clr) begin
            ovr_base_s = 16'd0;
        end else begin
            ovr_base_s = overrun_cnt_r;
        end
        if (frame_start && (state_r != ST_IDLE) && (ovr_base_s != 16'hFFFF)) begin
            overrun_cnt_s = ovr_base_s + 16'd1;
        end else begin
            overrun_cnt_s = ovr_base_s;
        end
        if (abort_s) begin
            timeout_err_s = 1'b1;
        end else if (err_clr) begin
            timeout_err_s = 1'b0;
        end else begin
            timeout_err_s = timeout_err_r;
        end
    end

    // State and output registers; the pulse outputs decode the state being entered.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_reset) begin
            state_r       <= ST_IDLE;
            nb_r          <= {BATCH_W{1'b0}};
            batch_idx_r   <= {BATCH_W{1'b0}};
            buf_base_r    <= 32'd0;
            wd_r          <= {TO_W{1'b0}};
            load_start_r  <= 1'b0;
            frame_done_r  <= 1'b0;
            abort_r       <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            overrun_cnt_r <= 16'd0;
        end else begin
            state_r       <= state_s;
            nb_r          <= nb_s;
            batch_idx_r   <= idx_s;
            buf_base_r    <= base_s;
            wd_r          <= wd_s;
            load_start_r  <= (state_s == ST_LAUNCH);
            frame_done_r  <= (state_s == ST_DONE);
            abort_r       <= abort_s;
            busy_r        <= (state_s != ST_IDLE);
            timeout_err_r <= timeout_err_s;
            overrun_cnt_r <= overrun_cnt_s;
        end
    end

    assign load_start  = load_start_r;
    assign frame_done  = frame_done_r;
    assign abort       = abort_r;
    assign busy        = busy_r;
    assign batch_idx   = batch_idx_r;
    assign buf_base    = buf_base_r;
    assign timeout_err = timeout_err_r;
    assign overrun_cnt = overrun_cnt_r;

endmodule

// File: tb/tb_tracer_frame_sched.sv
// Self-checking bench for tracer_frame_sched. It uses a short watchdog so that
// timeouts can be reached within the run. Expected load_start, frame_done and
// abort events are queued when a frame is launched. Each one is checked in
// order as the design raises it.
module tb_tracer_frame_sched;

    logic        clk;
    logic        s_axi_reset;
    logic        cfg_enable;
    logic [5:0]  cfg_num_batch;
    logic        frame_start;
    logic        load_start;
    logic        store_end;
    logic [5:0]  batch_idx;
    logic [31:0] buf_base;
    logic        busy;
    logic        frame_done;
    logic        abort;
    logic        timeout_err;
    logic [15:0] overrun_cnt;
    logic        err_clr;

    typedef struct {
        int          kind;   // 0 load_start, 1 frame_done, 2 abort
        logic [5:0]  idx;
        logic [31:0] base;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   failed    = 0;
    bit   mon_en    = 1'b1;

    tracer_frame_sched #(
        .BATCH_W     (6),
        .TO_W        (24),
        .TIMEOUT_CYC (24'd16),
        .BATCH_STRIDE(32'd64)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_reset  (s_axi_reset),
        .cfg_enable   (cfg_enable),
        .cfg_num_batch(cfg_num_batch),
        .frame_start  (frame_start),
        .load_start   (load_start),
        .store_end    (store_end),
        .batch_idx    (batch_idx),
        .buf_base     (buf_base),
        .busy         (busy),
        .frame_done   (frame_done),
        .abort        (abort),
        .timeout_err  (timeout_err),
        .overrun_cnt  (overrun_cnt),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    // Advance one cycle, then score any event pulse against the expected queue.
    task automatic tick();
        int   kind;
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en && (load_start || frame_done || abort)) begin
            kind = load_start ? 0 : (frame_done ? 1 : 2);
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL sb_unexpected: event kind=%0d idx=%0d base=%0d, none expected",
                         kind, batch_idx, buf_base);
            end else begin
                e = exp_q.pop_front();
                if (kind !== e.kind || batch_idx !== e.idx || buf_base !== e.base) begin
                    failed++;
                    $display("FAIL sb_event: got kind=%0d idx=%0d base=%0d, expected kind=%0d idx=%0d base=%0d",
                             kind, batch_idx, buf_base, e.kind, e.idx, e.base);
                end
            end
        end
    endtask

    task automatic push(input int kind, input int idx, input int base);
        exp_t e;
        e.kind = kind;
        e.idx  = 6'(idx);
        e.base = 32'(base);
        exp_q.push_back(e);
    endtask

    // Queue a normal frame: one load per batch, then frame_done on the last batch.
    task automatic push_frame(input int nb);
        for (int b = 0; b < nb; b++) push(0, b, b * 64);
        push(1, nb - 1, (nb - 1) * 64);
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return load_start;
            1:       return frame_done;
            2:       return abort;
            default: return ~busy;
        endcase
    endfunction

    // Poll a DUT signal for at most 'bound' cycles; n = cycles waited or -1.
    task automatic wait_for(input int which, input int bound, output int n);
        n = -1;
        for (int i = 0; i <= bound; i++) begin
            if (sig_of(which)) begin
                n = i;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Answer nb batches with store_end 'dly' cycles after each load_start.
    task automatic serve(input int nb, input int dly, input bit ovr);
        int n;
        for (int b = 0; b < nb; b++) begin
            wait_for(0, 40, n);
            tests_run++;
            if (n !== ((b == 0) ? 0 : 1)) begin
                failed++;
                $display("FAIL load_latency: batch %0d waited %0d cycles, expected %0d",
                         b, n, (b == 0) ? 0 : 1);
            end
            for (int d = 0; d < dly; d++) begin
                if (ovr && b == 1 && d == 2) frame_start = 1'b1;
                if (ovr && b == 2 && d == 2) begin
                    frame_start = 1'b1;
                    err_clr     = 1'b1;
                end
                if (ovr && b == 1 && d == 5) begin
                    tests_run++;
                    if (overrun_cnt !== 16'd1) begin
                        failed++;
                        $display("FAIL overrun_first: overrun_cnt=%0d expected 1", overrun_cnt);
                    end
                end
                tick();
                frame_start = 1'b0;
                err_clr     = 1'b0;
            end
            store_end = 1'b1;
            tick();
            store_end = 1'b0;
        end
    endtask

    task automatic check_queue_empty(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL %s_pending: %0d expected events never seen, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if ({load_start, busy, frame_done, abort, timeout_err} !== 5'b0) begin
            failed++;
            $display("FAIL %s_flags: ls/busy/fd/abort/terr=%b expected 00000", name,
                     {load_start, busy, frame_done, abort, timeout_err});
        end
        tests_run++;
        if (batch_idx !== 6'd0 || buf_base !== 32'd0) begin
            failed++;
            $display("FAIL %s_idx_base: idx=%0d base=%0d expected 0/0", name, batch_idx, buf_base);
        end
        tests_run++;
        if (overrun_cnt !== 16'd0) begin
            failed++;
            $display("FAIL %s_overrun: overrun_cnt=%0d expected 0", name, overrun_cnt);
        end
    endtask

    task automatic test_reset();
        s_axi_reset = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        s_axi_reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        int n;
        cfg_enable    = 1'b1;
        cfg_num_batch = 6'd3;
        push_frame(3);
        pulse_frame_start();
        serve(3, 10, 1'b0);
        wait_for(1, 10, n);
        tests_run++;
        if (n !== 1) begin
            failed++;
            $display("FAIL done_latency: frame_done after %0d cycles, expected 1", n);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL busy_in_done: busy=%b expected 1", busy);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            failed++;
            $display("FAIL busy_after_done: busy=%b frame_done=%b expected 0/0", busy, frame_done);
        end
        check_queue_empty("basic");
    endtask

    task automatic test_overrun();
        int n;
        cfg_num_batch = 6'd3;
        push_frame(3);
        pulse_frame_start();
        cfg_num_batch = 6'd9;   // must not affect the frame in flight
        serve(3, 10, 1'b1);
        tests_run++;
        if (overrun_cnt !== 16'd1) begin
            failed++;
            $display("FAIL overrun_clr_same_cycle: overrun_cnt=%0d expected 1", overrun_cnt);
        end
        wait_for(1, 10, n);
        tests_run++;
        if (n !== 1) begin
            failed++;
            $display("FAIL overrun_done: frame_done after %0d cycles, expected 1", n);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++;
        if (overrun_cnt !== 16'd0) begin
            failed++;
            $display("FAIL overrun_clear: overrun_cnt=%0d expected 0", overrun_cnt);
        end
        repeat (3) tick();
        check_queue_empty("overrun");
    endtask

    task automatic test_timeout();
        int n;
        cfg_num_batch = 6'd1;
        push(0, 0, 0);
        push(2, 0, 0);
        pulse_frame_start();
        wait_for(0, 5, n);
        wait_for(2, 40, n);
        tests_run++;
        if (n !== 17) begin
            failed++;
            $display("FAIL abort_latency: abort %0d cycles after load_start, expected 17", n);
        end
        tests_run++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL abort_state: timeout_err=%b busy=%b expected 1/0", timeout_err, busy);
        end
        tick();
        tests_run++;
        if (abort !== 1'b0 || frame_done !== 1'b0) begin
            failed++;
            $display("FAIL abort_pulse: abort=%b frame_done=%b expected 0/0", abort, frame_done);
        end
        // store_end in the 16th WAIT cycle must beat the watchdog
        push_frame(1);
        pulse_frame_start();
        wait_for(0, 5, n);
        repeat (16) tick();
        store_end = 1'b1;
        tick();
        store_end = 1'b0;
        wait_for(1, 10, n);
        tests_run++;
        if (n !== 1) begin
            failed++;
            $display("FAIL expiry_store_end: frame_done after %0d cycles, expected 1", n);
        end
        tests_run++;
        if (timeout_err !== 1'b1) begin
            failed++;
            $display("FAIL timeout_sticky: timeout_err=%b expected 1", timeout_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b0) begin
            failed++;
            $display("FAIL timeout_clear: timeout_err=%b expected 0", timeout_err);
        end
        check_queue_empty("timeout");
    endtask

    task automatic test_ignored_start();
        cfg_enable    = 1'b0;
        cfg_num_batch = 6'd2;
        pulse_frame_start();
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0 || load_start !== 1'b0) begin
            failed++;
            $display("FAIL disabled_start: busy=%b load_start=%b expected 0/0", busy, load_start);
        end
        cfg_enable    = 1'b1;
        cfg_num_batch = 6'd0;
        pulse_frame_start();
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0 || overrun_cnt !== 16'd0) begin
            failed++;
            $display("FAIL zero_batch_start: busy=%b overrun_cnt=%0d expected 0/0", busy, overrun_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        cfg_enable    = 1'b1;
        cfg_num_batch = 6'd3;
        push(0, 0, 0);
        push(0, 1, 64);
        push(0, 2, 128);
        pulse_frame_start();
        serve(2, 10, 1'b0);
        wait_for(0, 5, n);
        repeat (3) tick();
        s_axi_reset = 1'b1;
        tick();
        check_all_zero("reset_mid");
        s_axi_reset = 1'b0;
        repeat (2) tick();
        check_queue_empty("reset_mid");
        cfg_num_batch = 6'd2;
        push_frame(2);
        pulse_frame_start();
        serve(2, 4, 1'b0);
        wait_for(1, 10, n);
        tests_run++;
        if (n !== 1) begin
            failed++;
            $display("FAIL restart_done: frame_done after %0d cycles, expected 1", n);
        end
        tick();
        check_queue_empty("restart");
    endtask

    task automatic test_saturate_and_stray();
        int n;
        mon_en        = 1'b0;
        cfg_num_batch = 6'd1;
        frame_start   = 1'b1;
        repeat (72000) tick();
        frame_start   = 1'b0;
        tests_run++;
        if (overrun_cnt !== 16'hFFFF) begin
            failed++;
            $display("FAIL overrun_saturate: overrun_cnt=%h expected ffff", overrun_cnt);
        end
        wait_for(3, 40, n);
        tests_run++;
        if (n < 0) begin
            failed++;
            $display("FAIL idle_wait: busy still %b after 40 cycles, expected 0", busy);
        end
        mon_en    = 1'b1;
        store_end = 1'b1;
        tick();
        store_end = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0 || batch_idx !== 6'd0 || buf_base !== 32'd0 || overrun_cnt !== 16'hFFFF) begin
            failed++;
            $display("FAIL stray_store_end: busy=%b idx=%0d base=%0d ovr=%h expected 0/0/0/ffff",
                     busy, batch_idx, buf_base, overrun_cnt);
        end
    endtask

    initial begin
        s_axi_reset   = 1'b1;
        cfg_enable    = 1'b0;
        cfg_num_batch = 6'd0;
        frame_start   = 1'b0;
        store_end     = 1'b0;
        err_clr       = 1'b0;
        test_reset();
        test_basic_frame();
        test_overrun();
        test_timeout();
        test_ignored_start();
        test_reset_mid_frame();
        test_saturate_and_stray();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
